// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: fetch PC, req/ack instruction-memory port and a prefetch queue feeding IF/ID.
// Define IF_FETCH_STATS_EN to add the fetch_cnt_o / drop_cnt_o statistics counters.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'd0,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        valid_o,
   output logic [31:0] program_suppose_o,
`ifdef IF_FETCH_STATS_EN
   output logic [31:0] instruction_o,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] drop_cnt_o
`else
   output logic [31:0] instruction_o
`endif
);

   localparam int          AW      = $clog2(QUEUE_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(QUEUE_DEPTH);

   typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

   state_t        r_state, w_state_next;
   logic [31:0]   r_addr, w_addr_next;
   logic [31:0]   r_fetch_pc, w_fetch_pc_next;
   logic          r_stale, w_stale_next;
   logic [31:0]   r_q_instr [QUEUE_DEPTH];
   logic [31:0]   r_q_pc4   [QUEUE_DEPTH];
   logic [AW-1:0] r_rd_ptr, r_wr_ptr;
   logic [AW:0]   r_count, w_count_next;
   logic [31:0]   w_addr_inc;
   logic          w_ack, w_push, w_pop, w_valid, w_can_issue;

   always_comb begin
      w_addr_inc   = r_addr + 32'd4;
      w_valid      = (r_count != '0);
      w_ack        = (r_state == S_REQ) && imem_ack_i;
      // Stale data and data acked under a redirect are discarded, never queued.
      w_push       = w_ack && !r_stale && !redirect_i;
      w_pop        = w_valid && !stall_i && !redirect_i;
      w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (redirect_i)
         w_count_next = '0;
   end

   always_comb begin
      w_state_next    = r_state;
      w_addr_next     = r_addr;
      w_stale_next    = r_stale;
      w_fetch_pc_next = r_fetch_pc;
      w_can_issue     = 1'b0;
      // While stale, r_fetch_pc already holds the saved redirect target.
      if (redirect_i)
         w_fetch_pc_next = redirect_pc_i;
      else if (w_ack && !r_stale)
         w_fetch_pc_next = w_addr_inc;
      case (r_state)
         S_IDLE: begin
            w_can_issue = (r_count < DEPTH_C);
            if (w_can_issue) begin
               w_state_next = S_REQ;
               w_addr_next  = w_fetch_pc_next;
            end
         end
         S_REQ: begin
            w_can_issue = (w_count_next < DEPTH_C);
            if (w_ack) begin
               w_stale_next = 1'b0;
               if (w_can_issue)
                  w_addr_next = w_fetch_pc_next;
               else
                  w_state_next = S_IDLE;
            end else if (redirect_i) begin
               w_stale_next = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_addr     <= RESET_PC;
         r_fetch_pc <= RESET_PC;
         r_stale    <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_addr     <= w_addr_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_stale    <= w_stale_next;
         r_count    <= w_count_next;
         if (redirect_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push)
               r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_q_instr[r_wr_ptr] <= imem_data_i;
         r_q_pc4[r_wr_ptr]   <= w_addr_inc;
      end
   end

   assign imem_req_o        = (r_state == S_REQ);
   assign imem_addr_o       = r_addr;
   assign valid_o           = w_valid;
   assign program_suppose_o = w_valid ? r_q_pc4[r_rd_ptr] : 32'd0;
   assign instruction_o     = w_valid ? r_q_instr[r_rd_ptr] : 32'd0;

`ifdef IF_FETCH_STATS_EN
   logic [31:0] r_fetch_cnt, r_drop_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fetch_cnt <= 32'd0;
         r_drop_cnt  <= 32'd0;
      end else begin
         if (w_pop)
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (w_ack && (r_stale || redirect_i))
            r_drop_cnt <= r_drop_cnt + 32'd1;
      end
   end

   assign fetch_cnt_o = r_fetch_cnt;
   assign drop_cnt_o  = r_drop_cnt;
`else
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: cycle table from reset, then scoreboarded corner sequences.
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'd0;

   logic        clk_i, rst_i;
   logic        imem_req_o, imem_ack_i;
   logic [31:0] imem_addr_o, imem_data_i;
   logic        stall_i, redirect_i, valid_o;
   logic [31:0] redirect_pc_i, program_suppose_o, instruction_o;
`ifdef IF_FETCH_STATS_EN
   logic [31:0] fetch_cnt_o, drop_cnt_o;
`endif

   if_fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(2)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .imem_req_o        (imem_req_o),
      .imem_addr_o       (imem_addr_o),
      .imem_ack_i        (imem_ack_i),
      .imem_data_i       (imem_data_i),
      .stall_i           (stall_i),
      .redirect_i        (redirect_i),
      .redirect_pc_i     (redirect_pc_i),
      .valid_o           (valid_o),
      .program_suppose_o (program_suppose_o),
`ifdef IF_FETCH_STATS_EN
      .instruction_o     (instruction_o),
      .fetch_cnt_o       (fetch_cnt_o),
      .drop_cnt_o        (drop_cnt_o)
`else
      .instruction_o     (instruction_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int          checks   = 0;
   int          failures = 0;
   int          mem_lat  = 0;
   int          mem_wait = 0;
   logic        prev_req  = 1'b0;
   logic        prev_ack  = 1'b0;
   logic        chk_flush = 1'b0;
   logic [31:0] prev_addr = 32'd0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic        stall;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_ps;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic vec_t mk(input logic s, input logic rq, input logic [31:0] ad,
                               input logic v, input logic [31:0] ps);
      vec_t t;
      t.stall = s; t.exp_req = rq; t.exp_addr = ad; t.exp_valid = v; t.exp_ps = ps;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Program-order stream expected after reset or a redirect to pc.
   task automatic fill(input logic [31:0] pc);
      logic [31:0] p;
      p = pc;
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back({p + 32'd4, mem_word(p)});
         p = p + 32'd4;
      end
   endtask

   // One cycle: drive inputs + memory model, check outputs, advance to #1 after next edge.
   task automatic step(input logic stall, input logic redir, input logic [31:0] rpc, input logic late_ack);
      logic [63:0] e;
      stall_i       = stall;
      redirect_i    = redir;
      redirect_pc_i = redir ? rpc : $urandom;
      if (late_ack) begin
         imem_ack_i  = 1'b1;
         imem_data_i = $urandom;
      end else if (imem_req_o) begin
         if (mem_wait >= mem_lat) begin
            imem_ack_i  = 1'b1;
            imem_data_i = mem_word(imem_addr_o);
            mem_wait    = 0;
         end else begin
            imem_ack_i  = 1'b0;
            imem_data_i = $urandom;
            mem_wait++;
         end
      end else begin
         imem_ack_i  = 1'b0;
         imem_data_i = $urandom;
         mem_wait    = 0;
      end
      if (chk_flush)
         chk("flush_valid", 32'(valid_o), 32'd0);
      if (prev_req && !prev_ack) begin
         chk("req_held", 32'(imem_req_o), 32'd1);
         chk("addr_stable", imem_addr_o, prev_addr);
      end
      if (valid_o) begin
         if (!stall && !redir) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow: got ps %h expected no output", program_suppose_o);
            end else begin
               e = exp_q.pop_front();
               chk("sb_ps", program_suppose_o, e[63:32]);
               chk("sb_instr", instruction_o, e[31:0]);
            end
         end
      end else begin
         chk("bubble_ps", program_suppose_o, 32'd0);
         chk("bubble_instr", instruction_o, 32'd0);
      end
      if (redir)
         fill(rpc);
      chk_flush = redir;
      prev_req  = imem_req_o;
      prev_ack  = imem_ack_i;
      prev_addr = imem_addr_o;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [31:0] orig;
      int          last_v;
      int          nvalid;

      rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
      imem_ack_i = 1'b0; imem_data_i = 32'd0;
      repeat (3) @(posedge clk_i);
      #2;
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_addr", imem_addr_o, RESET_PC);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_ps", program_suppose_o, 32'd0);
      chk("rst_instr", instruction_o, 32'd0);
      rst_i = 1'b0;
      fill(RESET_PC);

      // Zero-wait memory from reset, then a 5-cycle stall that fills the queue.
      vecs[0]  = mk(1'b0, 1'b0, 32'd0,  1'b0, 32'd0);
      vecs[1]  = mk(1'b0, 1'b1, 32'd0,  1'b0, 32'd0);
      vecs[2]  = mk(1'b0, 1'b1, 32'd4,  1'b1, 32'd4);
      vecs[3]  = mk(1'b0, 1'b1, 32'd8,  1'b1, 32'd8);
      vecs[4]  = mk(1'b1, 1'b1, 32'd12, 1'b1, 32'd12);
      vecs[5]  = mk(1'b1, 1'b0, 32'd0,  1'b1, 32'd12);
      vecs[6]  = mk(1'b1, 1'b0, 32'd0,  1'b1, 32'd12);
      vecs[7]  = mk(1'b1, 1'b0, 32'd0,  1'b1, 32'd12);
      vecs[8]  = mk(1'b1, 1'b0, 32'd0,  1'b1, 32'd12);
      vecs[9]  = mk(1'b0, 1'b0, 32'd0,  1'b1, 32'd12);
      vecs[10] = mk(1'b0, 1'b0, 32'd0,  1'b1, 32'd16);
      vecs[11] = mk(1'b0, 1'b1, 32'd16, 1'b0, 32'd0);
      vecs[12] = mk(1'b0, 1'b1, 32'd20, 1'b1, 32'd20);
      vecs[13] = mk(1'b0, 1'b1, 32'd24, 1'b1, 32'd24);
      mem_lat = 0;
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("vec%0d_req", i), 32'(imem_req_o), 32'(vecs[i].exp_req));
         if (vecs[i].exp_req)
            chk($sformatf("vec%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
         chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_ps", i), program_suppose_o, vecs[i].exp_ps);
         chk($sformatf("vec%0d_instr", i), instruction_o,
             vecs[i].exp_valid ? mem_word(vecs[i].exp_ps - 32'd4) : 32'd0);
         step(vecs[i].stall, 1'b0, 32'd0, 1'b0);
      end

      // Latency 3: one word every 4 cycles, bubbles in between.
      mem_lat = 3;
      step(1'b0, 1'b1, 32'h1000, 1'b0);
      last_v = -1;
      nvalid = 0;
      for (int c = 0; c < 40; c++) begin
         if (valid_o) begin
            if (last_v >= 0)
               chk("lat3_gap", 32'(c - last_v), 32'd4);
            last_v = c;
            nvalid++;
         end
         step(1'b0, 1'b0, 32'd0, 1'b0);
      end
      chk("lat3_words_ge5", 32'(nvalid >= 5), 32'd1);

      // Redirect to 0x100 while the request to 0x8 is pending.
      step(1'b0, 1'b1, 32'h0, 1'b0);
      for (int k = 0; k < 60 && !(imem_req_o && imem_addr_o == 32'h8); k++)
         step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("wait_req8", 32'(imem_req_o && imem_addr_o == 32'h8), 32'd1);
      step(1'b0, 1'b1, 32'h100, 1'b0);
      for (int k = 0; k < 20 && !(imem_req_o && imem_addr_o != 32'h8); k++)
         step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("redir_next_addr", imem_addr_o, 32'h100);
      for (int k = 0; k < 20 && !valid_o; k++)
         step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("redir_first_ps", program_suppose_o, 32'h104);
      chk("redir_first_instr", instruction_o, mem_word(32'h100));

      // Redirect coinciding with an ack while stalled.
      mem_lat = 0;
      repeat (4) step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("t5_pre_req", 32'(imem_req_o), 32'd1);
      chk("t5_pre_valid", 32'(valid_o), 32'd1);
      step(1'b1, 1'b1, 32'h200, 1'b0);
      chk("t5_valid0", 32'(valid_o), 32'd0);
      chk("t5_req", 32'(imem_req_o), 32'd1);
      chk("t5_addr", imem_addr_o, 32'h200);
      repeat (6) step(1'b0, 1'b0, 32'd0, 1'b0);

      // Second redirect while the first is still stale overwrites the target.
      mem_lat = 3;
      for (int k = 0; k < 20 && !(imem_req_o && mem_wait == 0); k++)
         step(1'b0, 1'b0, 32'd0, 1'b0);
      orig = imem_addr_o;
      step(1'b0, 1'b1, 32'h300, 1'b0);
      step(1'b0, 1'b1, 32'h400, 1'b0);
      for (int k = 0; k < 20 && !(imem_req_o && imem_addr_o != orig); k++)
         step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("redir2_addr", imem_addr_o, 32'h400);
      repeat (12) step(1'b0, 1'b0, 32'd0, 1'b0);

      // Address wrap at the top of the address space.
      mem_lat = 0;
      step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
      for (int k = 0; k < 20 && !valid_o; k++)
         step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("wrap_ps_fc", program_suppose_o, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      for (int k = 0; k < 20 && !valid_o; k++)
         step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("wrap_ps_0", program_suppose_o, 32'd0);
      chk("wrap_instr", instruction_o, mem_word(32'hFFFF_FFFC));
      repeat (6) step(1'b0, 1'b0, 32'd0, 1'b0);

      // Asynchronous reset while a request is outstanding, then a late ack.
      mem_lat = 3;
      for (int k = 0; k < 20 && !imem_req_o; k++)
         step(1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("t6_pre_req", 32'(imem_req_o), 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("t6_rst_req", 32'(imem_req_o), 32'd0);
      chk("t6_rst_addr", imem_addr_o, RESET_PC);
      chk("t6_rst_valid", 32'(valid_o), 32'd0);
      chk("t6_rst_ps", program_suppose_o, 32'd0);
      chk("t6_rst_instr", instruction_o, 32'd0);
      @(posedge clk_i);
      #1;
      rst_i     = 1'b0;
      mem_wait  = 0;
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
      chk_flush = 1'b0;
      fill(RESET_PC);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("late_ack_valid", 32'(valid_o), 32'd0);
      chk("t6_first_req", 32'(imem_req_o), 32'd1);
      chk("t6_first_addr", imem_addr_o, RESET_PC);
      mem_lat = 0;
      repeat (8) step(1'b0, 1'b0, 32'd0, 1'b0);

      // Random stalls, latencies and redirects against the program-order scoreboard.
      for (int c = 0; c < 300; c++) begin
         logic s, r;
         if (c % 20 == 0)
            mem_lat = $urandom_range(0, 2);
         s = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 15) == 0) || (c % 64 == 63);
         step(s, r, $urandom & 32'hFFFF_FFFC, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
